led_step_sequencer: RTL and testbench

Controller for the dynamic LED colour cycler. The cycler advances its 3-bit colour (1..6, wrapping 6->1) on each clock that its `button` input is high. This block is the only driver of that input. It arbitrates between three step sources: a debounced manual push-button, a periodic auto-cycle timer, and a seek engine that steps the cycler to a requested colour. It watches the cycler's colour output as feedback.

---
 rtl/led_seq_pkg.sv | 26 ++
 rtl/led_step_sequencer_btn_debounce.sv | 48 ++++
 rtl/led_step_sequencer.sv | 150 +++++++++++++++
 tb/tb_led_step_sequencer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/led_seq_pkg.sv
// Shared encodings and constants for the LED step sequencer.
package led_seq_pkg;

  localparam logic [1:0] MODE_MANUAL = 2'b00;
  localparam logic [1:0] MODE_AUTO   = 2'b01;
  localparam logic [1:0] MODE_SEEK   = 2'b10;
  localparam logic [1:0] MODE_HOLD   = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_SEEK,
    ST_SETTLE,
    ST_DONE
  } state_t;

  localparam logic [2:0] COLOUR_MIN     = 3'd1;
  localparam logic [2:0] COLOUR_MAX     = 3'd6;
  localparam int         SEEK_MAX_STEPS = 6;

  // The cycler only ever reports 1..6; anything else can never be reached.
  function automatic logic colour_legal(input logic [2:0] c);
    return (c >= COLOUR_MIN) && (c <= COLOUR_MAX);
  endfunction

endpackage

// File: rtl/led_step_sequencer_btn_debounce.sv
// Push-button front end: 2-flop synchroniser, stability counter, and a
// one-cycle press pulse on each accepted 0->1 level change.
module btn_debounce
  import led_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  // Level flips only after DEBOUNCE_CYCLES consecutive differing samples;
  // any sample agreeing with the current level restarts the count.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 != level) begin
        if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          level <= sync2;
          cnt   <= '0;
          press <= sync2;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/led_step_sequencer.sv
// Drives the colour cycler's button input from one of three step sources
// (debounced button, auto timer, seek engine), one pulse at a time.
module led_step_sequencer
  import led_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int AUTO_PERIOD     = 8,
  parameter int STEP_GAP        = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_raw,
  input  logic [1:0] mode,
  input  logic [2:0] target,
  input  logic [2:0] colour_in,
  output logic       step,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] step_count
);

  localparam int TW = $clog2(AUTO_PERIOD + 1);
  localparam int GW = (STEP_GAP < 2) ? 1 : $clog2(STEP_GAP + 1);

  state_t        state;
  logic [TW-1:0] tmr;
  logic          auto_run;   // auto timer is counting (cleared on every step/mode exit)
  logic [GW-1:0] gap;
  logic [2:0]    seek_n;     // steps issued in the current seek
  logic [2:0]    seek_tgt;   // target that last finished (DONE) or faulted
  logic          seek_park;  // faulted seek: stay idle until target or mode changes
  logic          press;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_raw),
    .press   (press)
  );

  // Step FSM: SETTLE counts down untouched; every other cycle (and the
  // SETTLE exit cycle) dispatches on mode. Outputs are set with the state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_IDLE;
      tmr        <= '0;
      auto_run   <= 1'b0;
      gap        <= '0;
      seek_n     <= '0;
      seek_tgt   <= '0;
      seek_park  <= 1'b0;
      step       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      step_count <= '0;
    end else begin
      step <= 1'b0;
      if (state == ST_SETTLE && gap != '0) begin
        gap <= gap - 1'b1;
      end else begin
        busy <= 1'b0;
        done <= 1'b0;
        case (mode)
          MODE_HOLD: begin
            state     <= ST_IDLE;
            auto_run  <= 1'b0;
            seek_n    <= '0;
            seek_park <= 1'b0;
          end
          MODE_MANUAL: begin
            state     <= ST_RUN;
            auto_run  <= 1'b0;
            seek_n    <= '0;
            seek_park <= 1'b0;
            if (press) begin
              step  <= 1'b1;
              state <= ST_SETTLE;
              busy  <= 1'b1;
              gap   <= GW'(STEP_GAP);
              if (step_count != 8'hFF) step_count <= step_count + 8'd1;
            end
          end
          MODE_AUTO: begin
            seek_n    <= '0;
            seek_park <= 1'b0;
            if (!auto_run) begin
              // Fresh entry or SETTLE exit: this cycle is count 1.
              state    <= ST_RUN;
              auto_run <= 1'b1;
              tmr      <= TW'(1);
            end else if (tmr == TW'(AUTO_PERIOD - 1)) begin
              step     <= 1'b1;
              state    <= ST_SETTLE;
              busy     <= 1'b1;
              gap      <= GW'(STEP_GAP);
              auto_run <= 1'b0;
              tmr      <= '0;
              if (step_count != 8'hFF) step_count <= step_count + 8'd1;
            end else begin
              state <= ST_RUN;
              tmr   <= tmr + 1'b1;
            end
          end
          default: begin  // MODE_SEEK
            auto_run <= 1'b0;
            if ((state == ST_DONE || (state == ST_IDLE && seek_park)) &&
                target == seek_tgt) begin
              done <= (state == ST_DONE);
            end else if (!colour_legal(target)) begin
              err       <= 1'b1;
              state     <= ST_IDLE;
              seek_park <= 1'b1;
              seek_tgt  <= target;
              seek_n    <= '0;
            end else if (state != ST_SEEK) begin
              // Entry (or SETTLE return): compare on the following cycle.
              state     <= ST_SEEK;
              busy      <= 1'b1;
              seek_park <= 1'b0;
            end else if (colour_in == target) begin
              state    <= ST_DONE;
              done     <= 1'b1;
              seek_tgt <= target;
              seek_n   <= '0;
            end else if (seek_n == 3'(SEEK_MAX_STEPS)) begin
              // A full lap without a match: the cycler is not following.
              err       <= 1'b1;
              state     <= ST_IDLE;
              seek_park <= 1'b1;
              seek_tgt  <= target;
              seek_n    <= '0;
            end else begin
              step   <= 1'b1;
              state  <= ST_SETTLE;
              busy   <= 1'b1;
              gap    <= GW'(STEP_GAP);
              seek_n <= seek_n + 3'd1;
              if (step_count != 8'hFF) step_count <= step_count + 8'd1;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_led_step_sequencer.sv
// Directed bench for led_step_sequencer with a behavioural colour cycler.
module tb_led_step_sequencer;
  import led_seq_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_raw;
  logic [1:0] mode;
  logic [2:0] target;
  logic [2:0] colour_in;
  logic       step, busy, done, err;
  logic [7:0] step_count;

  // cycler model controls
  logic       cyc_load;
  logic [2:0] cyc_val;
  logic       frozen;

  int checks = 0;
  int errors = 0;
  int step_total = 0;
  int adj_bad = 0;
  logic prev_step = 1'b0;

  always #5 clk = ~clk;

  led_step_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .btn_raw    (btn_raw),
    .mode       (mode),
    .target     (target),
    .colour_in  (colour_in),
    .step       (step),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .step_count (step_count)
  );

  // Colour cycler: advances 1..6 with wrap on each clock that step is high.
  always @(posedge clk) begin
    if (cyc_load) colour_in <= cyc_val;
    else if (step && !frozen) colour_in <= (colour_in == 3'd6) ? 3'd1 : colour_in + 3'd1;
  end

  // Step pulse monitor: total count and back-to-back detection.
  always @(posedge clk) begin
    if (step) step_total <= step_total + 1;
    if (step && prev_step) adj_bad <= adj_bad + 1;
    prev_step <= step;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic do_reset(input logic [1:0] m, input logic [2:0] c, input logic frz);
    @(negedge clk);
    rst = 1'b0; mode = m; btn_raw = 1'b0; target = 3'd1;
    cyc_load = 1'b1; cyc_val = c; frozen = frz;
    repeat (2) @(negedge clk);
    rst = 1'b1; cyc_load = 1'b0;
  endtask

  typedef struct {
    logic [2:0] colour;
    logic [2:0] target;
    logic       frozen;
    int         steps;
    logic       done;
    logic       err;
    logic [2:0] fin;
  } vec_t;

  vec_t vec [7];

  initial begin
    int first, at, nst, last, bad, base;
    logic wrapped;
    logic [2:0] prev_col;

    vec[0] = '{3'd5, 3'd2, 1'b0, 3, 1'b1, 1'b0, 3'd2};  // wraps 5->6->1->2
    vec[1] = '{3'd4, 3'd4, 1'b0, 0, 1'b1, 1'b0, 3'd4};  // already there
    vec[2] = '{3'd1, 3'd6, 1'b0, 5, 1'b1, 1'b0, 3'd6};
    vec[3] = '{3'd6, 3'd1, 1'b0, 1, 1'b1, 1'b0, 3'd1};
    vec[4] = '{3'd3, 3'd7, 1'b0, 0, 1'b0, 1'b1, 3'd3};  // illegal target
    vec[5] = '{3'd3, 3'd0, 1'b0, 0, 1'b0, 1'b1, 3'd3};  // illegal target
    vec[6] = '{3'd3, 3'd4, 1'b1, 6, 1'b0, 1'b1, 3'd3};  // frozen cycler

    // Reset held 3 cycles with the button pressed in AUTO.
    rst = 1'b0; mode = MODE_AUTO; btn_raw = 1'b1; target = 3'd1;
    cyc_load = 1'b1; cyc_val = 3'd1; frozen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_step", step, 0);
      chk("rst_count", step_count, 0);
      chk("rst_err", err, 0);
      chk("rst_done", done, 0);
    end
    rst = 1'b1; cyc_load = 1'b0;
    first = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (step && first < 0) first = k;
    end
    chk("auto_first_step_cycle", first, 8);

    // MANUAL: bounce then stable press, then release.
    do_reset(MODE_MANUAL, 3'd1, 1'b0);
    nst = 0; at = -1;
    for (int i = 0; i < 10; i++) begin
      btn_raw = (i % 2 == 0);
      @(negedge clk);
      if (step) nst++;
    end
    btn_raw = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (step) begin nst++; at = i; end
    end
    btn_raw = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (step) nst++;
    end
    chk("manual_pulses", nst, 1);
    chk("manual_latency", at, 6);
    chk("manual_count", step_count, 1);

    // AUTO for 100 cycles.
    do_reset(MODE_AUTO, 3'd1, 1'b0);
    nst = 0; last = -1; bad = 0; first = -1; wrapped = 1'b0; prev_col = colour_in;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (step) begin
        if (first < 0) first = k;
        if (last > 0 && (k - last) != 10) bad++;
        last = k; nst++;
      end
      if (prev_col == 3'd6 && colour_in == 3'd1) wrapped = 1'b1;
      prev_col = colour_in;
    end
    chk("auto_steps", nst, 10);
    chk("auto_first", first, 8);
    chk("auto_bad_spacing", bad, 0);
    chk("auto_wrapped", wrapped, 1);
    chk("auto_colour", colour_in, 5);
    chk("auto_count", step_count, 10);

    // SEEK vector table.
    for (int r = 0; r < 7; r++) begin
      do_reset(MODE_HOLD, vec[r].colour, vec[r].frozen);
      base = step_total;
      mode = MODE_SEEK; target = vec[r].target;
      repeat (60) @(negedge clk);
      chk($sformatf("seek%0d_steps", r), step_total - base, vec[r].steps);
      chk($sformatf("seek%0d_count", r), step_count, vec[r].steps);
      chk($sformatf("seek%0d_done", r), done, vec[r].done);
      chk($sformatf("seek%0d_err", r), err, vec[r].err);
      chk($sformatf("seek%0d_busy", r), busy, 0);
      chk($sformatf("seek%0d_colour", r), colour_in, vec[r].fin);
    end

    // Illegal target flagged on the very next edge.
    do_reset(MODE_HOLD, 3'd3, 1'b0);
    mode = MODE_SEEK; target = 3'd7;
    @(negedge clk);
    chk("illegal_err_next", err, 1);
    chk("illegal_no_step", step, 0);

    // SEEK -> HOLD while settling.
    do_reset(MODE_HOLD, 3'd1, 1'b0);
    mode = MODE_SEEK; target = 3'd4;
    first = -1;
    for (int k = 0; k < 20 && first < 0; k++) begin
      @(negedge clk);
      if (step) first = k;
    end
    chk("hold_step_seen", first >= 0, 1);
    mode = MODE_HOLD;
    @(negedge clk);
    chk("hold_busy_settle", busy, 1);
    repeat (20) @(negedge clk);
    chk("hold_count", step_count, 1);
    chk("hold_busy_after", busy, 0);
    chk("hold_colour", colour_in, 2);

    // DONE holds, then a target change re-seeks.
    do_reset(MODE_HOLD, 3'd2, 1'b0);
    mode = MODE_SEEK; target = 3'd2;
    repeat (5) @(negedge clk);
    chk("done_hold", done, 1);
    target = 3'd3;
    repeat (12) @(negedge clk);
    chk("reseek_done", done, 1);
    chk("reseek_count", step_count, 1);
    chk("reseek_colour", colour_in, 3);

    // Reset in the middle of a seek.
    do_reset(MODE_HOLD, 3'd1, 1'b0);
    mode = MODE_SEEK; target = 3'd5;
    first = -1;
    for (int k = 0; k < 20 && first < 0; k++) begin
      @(negedge clk);
      if (step) first = k;
    end
    chk("midrst_step_seen", first >= 0, 1);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_step", step, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_err", err, 0);
    chk("midrst_count", step_count, 0);
    rst = 1'b1; mode = MODE_HOLD;
    repeat (3) @(negedge clk);

    chk("no_adjacent_steps", adj_bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
